// File: rtl/gsim_mtx_fetch_if.sv
// rtl/gsim_mtx_fetch_if.sv - handshake/bus bundle between the matrix fetch block and its environment
//
// Purpose: carries the start command, the matrix-memory read request and response,
//          the row stream to the GSIM core, and the status outputs.
// Ports (modport master = fetch block, slave = environment):
//   i_start, i_matrix_num                   start one matrix fetch
//   o_mem_rreq, o_mem_addr, i_mem_rrdy      memory read request with ready
//   i_mem_dout, i_mem_dout_vld              in-order memory response
//   o_row_vld, i_row_rdy, o_row_data,
//   o_row_idx, o_row_last                   row stream to the core
//   o_busy, o_done                          status
//   o_err                                   sticky error, only with GSIM_FETCH_ERR_EN
interface gsim_mtx_fetch_if;
  logic         i_start;
  logic [4:0]   i_matrix_num;
  logic         o_mem_rreq;
  logic [9:0]   o_mem_addr;
  logic         i_mem_rrdy;
  logic [255:0] i_mem_dout;
  logic         i_mem_dout_vld;
  logic         o_row_vld;
  logic         i_row_rdy;
  logic [255:0] o_row_data;
  logic [4:0]   o_row_idx;
  logic         o_row_last;
  logic         o_busy;
  logic         o_done;
`ifdef GSIM_FETCH_ERR_EN
  logic         o_err;

  modport master (
    input  i_start, i_matrix_num, i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_row_rdy,
    output o_mem_rreq, o_mem_addr, o_row_vld, o_row_data, o_row_idx, o_row_last,
           o_busy, o_done, o_err
  );

  modport slave (
    output i_start, i_matrix_num, i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_row_rdy,
    input  o_mem_rreq, o_mem_addr, o_row_vld, o_row_data, o_row_idx, o_row_last,
           o_busy, o_done, o_err
  );
`else
  modport master (
    input  i_start, i_matrix_num, i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_row_rdy,
    output o_mem_rreq, o_mem_addr, o_row_vld, o_row_data, o_row_idx, o_row_last,
           o_busy, o_done
  );

  modport slave (
    output i_start, i_matrix_num, i_mem_rrdy, i_mem_dout, i_mem_dout_vld, i_row_rdy,
    input  o_mem_rreq, o_mem_addr, o_row_vld, o_row_data, o_row_idx, o_row_last,
           o_busy, o_done
  );
`endif
endinterface

// File: rtl/gsim_mtx_fetch.sv
// rtl/gsim_mtx_fetch.sv - fetches one 17-row matrix (A rows 0..15, b row 16) into the GSIM core
//
// Purpose: on i_start, reads 17 consecutive words from base = i_matrix_num*17, buffers the
//          in-order responses in a 4-entry FIFO and streams them out as rows with index.
// Ports:
//   i_clk      sole clock, rising edge
//   i_reset    asynchronous, active-high reset
//   bus        gsim_mtx_fetch_if.master (start, memory request/response, row stream, status)
// Option: GSIM_FETCH_ERR_EN adds sticky bus.o_err (dropped response or start while busy).
module gsim_mtx_fetch (
  input logic              i_clk,
  input logic              i_reset,
  gsim_mtx_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t       state;
  logic [255:0] fifo_data [4];
  logic [4:0]   fifo_idx  [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic [2:0]   count;
  logic [2:0]   outst;
  logic [4:0]   req_cnt;
  logic [4:0]   resp_idx;
  logic [9:0]   addr;
  logic         rreq;
  logic         busy;
  logic         done;

  logic         acc;
  logic         push;
  logic         pop;
  logic         fifo_nonempty;
  logic [2:0]   count_n;
  logic [2:0]   outst_n;
  logic [3:0]   credit_sum_n;
  logic [9:0]   base;

  always_comb begin
    acc           = rreq & bus.i_mem_rrdy;
    // A response with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
    push          = bus.i_mem_dout_vld & (outst != 3'd0);
    fifo_nonempty = (count != 3'd0);
    pop           = fifo_nonempty & bus.i_row_rdy;
    outst_n       = outst + {2'b00, acc} - {2'b00, push};
    count_n       = count + {2'b00, push} - {2'b00, pop};
    credit_sum_n  = {1'b0, count_n} + {1'b0, outst_n};
    base          = ({5'd0, bus.i_matrix_num} << 4) + {5'd0, bus.i_matrix_num};
  end

`ifdef GSIM_FETCH_ERR_EN
  logic err;
  assign bus.o_err = err;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      outst    <= 3'd0;
      req_cnt  <= 5'd0;
      resp_idx <= 5'd0;
      addr     <= 10'd0;
      rreq     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef GSIM_FETCH_ERR_EN
      err      <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 2'd1;
        resp_idx <= resp_idx + 5'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count_n;
      outst <= outst_n;
      if (acc) begin
        addr    <= addr + 10'd1;
        req_cnt <= req_cnt + 5'd1;
      end
      done <= 1'b0;
`ifdef GSIM_FETCH_ERR_EN
      if ((bus.i_mem_dout_vld && outst == 3'd0) || (bus.i_start && state != IDLE)) begin
        err <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state    <= FETCH;
            addr     <= base;
            req_cnt  <= 5'd0;
            resp_idx <= 5'd0;
            rreq     <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (acc && req_cnt == 5'd16) begin
            state <= DRAIN;
            rreq  <= 1'b0;
          end else if (rreq && !acc) begin
            rreq <= 1'b1;
          end else begin
            // A new request is only raised if it can be accepted without the
            // FIFO plus in-flight responses ever exceeding four entries.
            rreq <= (credit_sum_n < 4'd4);
          end
        end
        DRAIN: begin
          if (pop && fifo_idx[rd_ptr] == 5'd16) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row storage carries no reset; the outputs are gated to zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.i_mem_dout;
      fifo_idx[wr_ptr]  <= resp_idx;
    end
  end

  assign bus.o_mem_rreq = rreq;
  assign bus.o_mem_addr = addr;
  assign bus.o_row_vld  = fifo_nonempty;
  assign bus.o_row_data = fifo_nonempty ? fifo_data[rd_ptr] : 256'd0;
  assign bus.o_row_idx  = fifo_nonempty ? fifo_idx[rd_ptr] : 5'd0;
  assign bus.o_row_last = fifo_nonempty && (fifo_idx[rd_ptr] == 5'd16);
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;

endmodule

// File: tb/tb_gsim_mtx_fetch.sv
// tb/tb_gsim_mtx_fetch.sv - scoreboard bench for gsim_mtx_fetch
module tb_gsim_mtx_fetch;

  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  gsim_mtx_fetch_if bus ();

  gsim_mtx_fetch dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0]   exp_addr_q [$];
  logic [255:0] exp_data_q [$];
  logic [4:0]   exp_idx_q  [$];
  int           resp_addr_q [$];
  int           resp_due_q  [$];

  int cyc = 0;
  int last_due = 0;
  int lat_min = 1, lat_max = 1;
  int rrdy_mode = 0;
  int rdy_mode = 0;
  int stall_left = 0;
  int spurious = 0;
  int n_req, n_pop, n_stall, n_done, first_pop_cyc, last_pop_cyc, done_cyc;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_word(input int a);
    logic [255:0] w;
    for (int j = 0; j < 16; j++) w[j*16 +: 16] = {a[9:0], j[5:0]};
    return w;
  endfunction

  // Environment: memory model, row sink and scoreboard, all stepped on the falling edge.
  always @(negedge i_clk) begin
    cyc++;
    bus.i_mem_dout_vld = 1'b0;
    if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
      void'(resp_due_q.pop_front());
      bus.i_mem_dout     = mem_word(resp_addr_q.pop_front());
      bus.i_mem_dout_vld = 1'b1;
    end
    if (spurious != 0) begin
      bus.i_mem_dout     = {8{32'hdeadbeef}};
      bus.i_mem_dout_vld = 1'b1;
      spurious = 0;
    end
    if (stall_left > 0 && bus.o_mem_rreq) begin
      bus.i_mem_rrdy = 1'b0;
      stall_left--;
      n_stall++;
    end else begin
      bus.i_mem_rrdy = (rrdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    case (rdy_mode)
      0: bus.i_row_rdy = 1'b1;
      1: bus.i_row_rdy = 1'b0;
      default: bus.i_row_rdy = 1'($urandom_range(0, 1));
    endcase
    if (!i_reset) begin
      if (bus.o_mem_rreq && !bus.i_mem_rrdy && exp_addr_q.size() > 0)
        check_eq("addr_hold", bus.o_mem_addr, exp_addr_q[0]);
      if (bus.o_mem_rreq && bus.i_mem_rrdy) begin
        int lat, due;
        n_req++;
        check_eq("addr_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) check_eq("addr", bus.o_mem_addr, exp_addr_q.pop_front());
        lat = $urandom_range(lat_min, lat_max);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        resp_addr_q.push_back(int'(bus.o_mem_addr));
        resp_due_q.push_back(due);
      end
      if (bus.o_row_vld && bus.i_row_rdy) begin
        check_eq("row_expected", exp_idx_q.size() != 0, 1);
        if (exp_idx_q.size() != 0) begin
          logic [4:0] ei;
          ei = exp_idx_q.pop_front();
          check_eq("row_idx", bus.o_row_idx, ei);
          check_eq("row_data", bus.o_row_data, exp_data_q.pop_front());
          check_eq("row_last", bus.o_row_last, ei == 5'd16);
        end
        if (n_pop == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        n_pop++;
      end
      if (bus.o_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    n_req = 0; n_pop = 0; n_stall = 0; n_done = 0;
    first_pop_cyc = 0; last_pop_cyc = 0; done_cyc = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rreq"}, bus.o_mem_rreq, 0);
    check_eq({tag, "_addr"}, bus.o_mem_addr, 0);
    check_eq({tag, "_row_vld"}, bus.o_row_vld, 0);
    check_eq({tag, "_row_data"}, bus.o_row_data, 0);
    check_eq({tag, "_row_idx"}, bus.o_row_idx, 0);
    check_eq({tag, "_row_last"}, bus.o_row_last, 0);
    check_eq({tag, "_busy"}, bus.o_busy, 0);
    check_eq({tag, "_done"}, bus.o_done, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    repeat (8) @(negedge i_clk);
    exp_addr_q.delete(); exp_data_q.delete(); exp_idx_q.delete();
    resp_addr_q.delete(); resp_due_q.delete();
    stall_left = 0;
    i_reset = 1'b0;
  endtask

  task automatic run_matrix(input int num);
    int base;
    base = num * 17;
    for (int i = 0; i < 17; i++) begin
      exp_addr_q.push_back(10'(base + i));
      exp_data_q.push_back(mem_word(base + i));
      exp_idx_q.push_back(5'(i));
    end
    @(negedge i_clk);
    bus.i_matrix_num = 5'(num);
    bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    check_eq("busy_run", bus.o_busy, 1);
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (n_done == 0 && n < max_cycles) begin
      @(negedge i_clk);
      n++;
    end
    check_eq({tag, "_done_seen"}, n_done != 0, 1);
    repeat (3) @(negedge i_clk);
    check_eq({tag, "_done_once"}, n_done, 1);
    check_eq({tag, "_req_count"}, n_req, 17);
    check_eq({tag, "_rows_left"}, exp_idx_q.size(), 0);
    check_eq({tag, "_busy_after"}, bus.o_busy, 0);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_matrix_num = 5'd0;
    bus.i_mem_rrdy = 1'b0;
    bus.i_mem_dout = '0;
    bus.i_mem_dout_vld = 1'b0;
    bus.i_row_rdy = 1'b0;
    i_reset = 1'b1;
    clear_stats();
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;

    // Matrix 2, full-speed memory and core.
    clear_stats();
    lat_min = 1; lat_max = 1; rrdy_mode = 0; rdy_mode = 0;
    run_matrix(2);
    wait_done("full", 200);
    check_eq("full_consecutive", last_pop_cyc - first_pop_cyc, 16);
    check_eq("full_done_latency", done_cyc - last_pop_cyc, 1);

    // Core never ready: credit limit stops requests at four.
    clear_stats();
    rdy_mode = 1;
    run_matrix(3);
    repeat (20) @(negedge i_clk);
    check_eq("stuck_req_count", n_req, 4);
    check_eq("stuck_rreq", bus.o_mem_rreq, 0);
    check_eq("stuck_row_vld", bus.o_row_vld, 1);
    check_eq("stuck_row_idx", bus.o_row_idx, 0);
    check_eq("stuck_row_data", bus.o_row_data, mem_word(51));
    rdy_mode = 0;
    do_reset("rst_stuck");

    // First request stalled five cycles.
    clear_stats();
    stall_left = 5;
    run_matrix(4);
    wait_done("stall", 300);
    check_eq("stall_cycles", n_stall, 5);

    // Matrix 31, random latency and random core ready.
    clear_stats();
    lat_min = 1; lat_max = 6; rrdy_mode = 1; rdy_mode = 2;
    run_matrix(31);
    wait_done("rand", 2000);

    // Reset after row 5, then a clean fetch of matrix 0.
    clear_stats();
    run_matrix(7);
    begin
      int n;
      n = 0;
      while (n_pop < 6 && n < 500) begin
        @(negedge i_clk);
        n++;
      end
      check_eq("mid_rows_seen", n_pop >= 6, 1);
    end
    do_reset("rst_mid");
    clear_stats();
    lat_min = 1; lat_max = 3;
    run_matrix(0);
    wait_done("after_rst", 2000);

`ifdef GSIM_FETCH_ERR_EN
    // Spurious response in IDLE sets the sticky error and emits no row.
    check_eq("err_clear", bus.o_err, 0);
    @(negedge i_clk);
    spurious = 1;
    repeat (4) @(negedge i_clk);
    check_eq("err_set", bus.o_err, 1);
    check_eq("err_no_row", bus.o_row_vld, 0);
    repeat (4) @(negedge i_clk);
    check_eq("err_sticky", bus.o_err, 1);
    do_reset("rst_err");
    #1;
    check_eq("err_reset", bus.o_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
